tx_serializer: RTL and testbench
================================

// Module: tx_serializer
// PURPOSE
//  UART transmit datapath and control: accepts one data word per valid/ready handshake
//  and serializes it onto tx as start, data LSB first, optional parity, then 1 or 2 stop bits.
//  Bit timing is paced by an external one-cycle baud_tick strobe, one strobe per bit period.
//  Frame format is the same runtime-configurable width/parity/stop scheme the receive path decodes.
// PARAMETERS
//  UART_DATA_WIDTH  8  max data bits per frame; sets tx_data width
//  WIDTH_BITS       $clog2(UART_DATA_WIDTH+1)  width of uart_data_width input
// PORTS
//  clk              in   1               system clock, all logic rising-edge
//  n_rst            in   1               async active-low reset
//  baud_tick        in   1               one-cycle strobe, marks end of current bit period
//  tx_valid         in   1               tx_data holds a word to send
//  tx_ready         out  1               block can accept a word this cycle
//  tx_data          in   UART_DATA_WIDTH data word; bits >= uart_data_width ignored
//  uart_data_width  in   WIDTH_BITS      data bits per frame, 1..UART_DATA_WIDTH
//  parity_en        in   1               1: append parity bit
//  parity_odd       in   1               1: odd parity, 0: even
//  stop2            in   1               1: two stop bits, 0: one
//  baud_restart     out  1               1-cycle pulse on accept; lets baud gen re-phase
//  tx               out  1               serial line, idle high
//  tx_busy          out  1               frame in progress (state != IDLE)
//  tx_done          out  1               1-cycle pulse when final stop bit ends
// BEHAVIOUR
//  - Reset (async, n_rst=0): state IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0,
//    baud_restart=0, shift reg/counters cleared. Reset mid-frame aborts; tx high at once.
//  - tx is registered; no combinational path from any input to tx.
//  - Accept: tx_valid & tx_ready at edge -> load shift reg with tx_data, latch width,
//    parity_en, parity_odd, stop2; compute parity = ^(tx_data masked to width), inverted
//    if parity_odd; go START; baud_restart=1 that cycle (combinational from handshake).
//  - Config inputs changing mid-frame have no effect on the frame in flight.
//  - Width rule: uart_data_width==0 or >UART_DATA_WIDTH -> UART_DATA_WIDTH used.
//  - FSM, each bit state ends on baud_tick; tx shows new bit the cycle after that tick:
//    IDLE  : tx=1, tx_ready=1; -> START on accept.
//    START : tx=0; tick -> DATA, bit_cnt=0.
//    DATA  : tx=shift[0]; tick -> shift right, bit_cnt++; at bit_cnt==width-1 tick ->
//            PARITY if parity_en else STOP.
//    PARITY: tx=parity; tick -> STOP, stop_cnt=0.
//    STOP  : tx=1; tick -> if stop2 & stop_cnt==0 stay, stop_cnt=1; else -> IDLE, tx_done=1.
//  - tx_ready=1 only in IDLE; tx_busy=!tx_ready. Back-to-back: word offered during the
//    tx_done cycle is accepted next cycle (IDLE), so line gap is >=1 clk high beyond stop.
//  - baud_tick in IDLE ignored. baud_tick coinciding with accept ignored (START begins).
//  - tx_valid deasserted before acceptance: no frame; valid may drop freely while ready=0.
//  - Frame length = 1 + width + parity_en + (1+stop2) ticks after START entry.
// TESTING
//  - 8N1, tx_data=0xA5, tick every 16 clk -> tx per bit: 0,1,0,1,0,0,1,0,1,1; one tx_done.
//  - 7E1, tx_data=0xC1 (bit7 ignored) -> 0,1,0,0,0,0,0,1,0(parity),1; data bits = 0x41.
//  - 5O2, tx_data=0x1F -> 0,1,1,1,1,1,0(parity),1,1; tx_done after 2nd stop tick only.
//  - Back-to-back: tx_valid held high, 0x55 then 0xAA 8N1 -> ready low whole frame,
//    second accept exactly 1 clk after tx_done, both frames bit-exact.
//  - Reset asserted during DATA bit 3 -> tx=1, tx_ready=1 same cycle; post-reset 0x3C sent clean.
//  - width=0 with 0xFF, no parity -> 8 data bits sent; config flip mid-frame -> frame unchanged.

Source files
------------

// File: rtl/tx_serializer.sv
// UART transmit serializer: one word per valid/ready handshake, sent as start, LSB-first data,
// optional parity and 1 or 2 stop bits, with bit periods paced by an external baud_tick strobe.
module tx_serializer #(
  parameter int unsigned UART_DATA_WIDTH = 8,
  parameter int unsigned WIDTH_BITS      = $clog2(UART_DATA_WIDTH + 1)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       baud_tick,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [UART_DATA_WIDTH-1:0] tx_data,
  input  logic [WIDTH_BITS-1:0]      uart_data_width,
  input  logic                       parity_en,
  input  logic                       parity_odd,
  input  logic                       stop2,
  output logic                       baud_restart,
  output logic                       tx,
  output logic                       tx_busy,
  output logic                       tx_done
);

  localparam logic [WIDTH_BITS-1:0] MAX_WIDTH = WIDTH_BITS'(UART_DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                     state_q, state_d;
  logic [UART_DATA_WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH_BITS-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WIDTH_BITS-1:0]      width_q, width_d;
  logic                       par_en_q, par_en_d;
  logic                       par_bit_q, par_bit_d;
  logic                       stop2_q, stop2_d;
  logic                       stop_cnt_q, stop_cnt_d;
  logic                       tx_q, tx_d;

  logic [WIDTH_BITS-1:0]      width_eff;
  logic [UART_DATA_WIDTH-1:0] data_masked;
  logic [UART_DATA_WIDTH-1:0] shift_nxt;
  logic                       parity_calc;
  logic                       accept;

  // Decode the frame configuration offered alongside the word
  always_comb begin
    width_eff = uart_data_width;
    if (uart_data_width == '0 || uart_data_width > MAX_WIDTH) begin
      width_eff = MAX_WIDTH;
    end
    data_masked = '0;
    for (int i = 0; i < UART_DATA_WIDTH; i++) begin
      data_masked[i] = tx_data[i] & (WIDTH_BITS'(i) < width_eff);
    end
    parity_calc = (^data_masked) ^ parity_odd;
  end

  assign accept       = tx_valid && (state_q == ST_IDLE);
  assign shift_nxt    = shift_q >> 1;
  assign baud_restart = accept;
  assign tx_ready     = (state_q == ST_IDLE);
  assign tx_busy      = ~tx_ready;
  assign tx           = tx_q;

  // Next-state logic; tx_d carries the level of the bit being entered
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    width_d    = width_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    tx_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          shift_d    = data_masked;
          width_d    = width_eff;
          par_en_d   = parity_en;
          par_bit_d  = parity_calc;
          stop2_d    = stop2;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = ST_START;
          tx_d       = 1'b0;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == width_q - WIDTH_BITS'(1)) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = ST_STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            shift_d   = shift_nxt;
            bit_cnt_d = bit_cnt_q + WIDTH_BITS'(1);
            tx_d      = shift_nxt[0];
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_done = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      width_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      width_q    <= width_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: directed frame formats, back-to-back, mid-frame reset and random frames
// compared against a frame-level model of the serial line.
module tb_tx_serializer;

  localparam int unsigned DW = 8;
  localparam int unsigned WB = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          baud_tick;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] tx_data = '0;
  logic [WB-1:0] uart_data_width = '0;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          stop2 = 1'b0;
  logic          baud_restart;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  int errors = 0;
  int checks = 0;

  int unsigned div = 16;
  bit          restart_en = 1'b1;
  int unsigned tcnt = 0;

  logic exp_q[$];
  logic obs_q[$];
  logic done_q[$];
  int   busy_bad;

  tx_serializer #(.UART_DATA_WIDTH(DW)) dut (
    .clk(clk), .n_rst(n_rst), .baud_tick(baud_tick), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .uart_data_width(uart_data_width),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .baud_restart(baud_restart), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // Baud generator, optionally re-phased by baud_restart
  always @(posedge clk) begin
    if ((restart_en && baud_restart) || (tcnt + 1 >= div)) tcnt <= 0;
    else tcnt <= tcnt + 1;
  end
  assign baud_tick = (tcnt == div - 1);

  // Expected line levels, one entry per bit period
  function automatic void model(input logic [7:0] d, input int w, input bit pe, input bit po, input bit s2);
    int n;
    int ones;
    n = (w == 0 || w > int'(DW)) ? int'(DW) : w;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) exp_q.push_back(((ones % 2) == 1) ^ po);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endfunction

  // Offer a word; returns in the accept cycle (just after a falling edge)
  task automatic offer(input logic [7:0] d, input logic [3:0] w, input bit pe, input bit po,
                       input bit s2, output bit ok);
    tx_data = d; uart_data_width = WB'(w); parity_en = pe; parity_odd = po; stop2 = s2;
    tx_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Record tx and tx_done at each bit-period end of the frame just accepted
  task automatic collect(input int nbits, input bit keep_valid, input logic [7:0] next_data,
                         input bit flip, output bit ok);
    obs_q.delete(); done_q.delete(); busy_bad = 0; ok = 1'b1;
    for (int k = 0; k < nbits; k++) begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk); #1;
        if (k == 0 && c == 0) begin
          if (!keep_valid) tx_valid = 1'b0;
          else tx_data = next_data;
          if (flip) begin
            uart_data_width = WB'(3); parity_en = ~parity_en; parity_odd = ~parity_odd;
            stop2 = ~stop2; tx_data = ~tx_data;
          end
        end
        if (tx_ready !== 1'b0 || tx_busy !== 1'b1) busy_bad++;
        if (baud_tick) begin
          obs_q.push_back(tx);
          done_q.push_back(tx_done);
          got = 1'b1;
        end
      end
      if (!got) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b want=1", tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", tx_ready); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", tx_done); end
    checks++; if (baud_restart !== 1'b0) begin errors++; $display("FAIL reset_restart got=%b want=0", baud_restart); end
    @(negedge clk); n_rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (tx_ready !== 1'b1 || tx !== 1'b1) begin
      errors++; $display("FAIL idle_hold ready=%b tx=%b want 1/1", tx_ready, tx);
    end
  endtask

  task automatic test_frame(input string name, input logic [7:0] d, input logic [3:0] w,
                            input bit pe, input bit po, input bit s2, input bit flip);
    bit ok;
    int nd;
    model(d, int'(w), pe, po, s2);
    offer(d, w, pe, po, s2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s accept_timeout got=0 want=1", name); return; end
    checks++; if (baud_restart !== 1'b1) begin errors++; $display("FAIL %s restart got=%b want=1", name, baud_restart); end
    collect(exp_q.size(), 1'b0, 8'h00, flip, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s tick_timeout got=%0d want=%0d bits", name, obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s bit%0d got=%b want=%b", name, i, obs_q[i], exp_q[i]);
      end
    end
    nd = 0;
    for (int i = 0; i < done_q.size(); i++) if (done_q[i] !== (i == done_q.size() - 1)) nd++;
    checks++; if (nd != 0 || done_q.size() == 0) begin errors++; $display("FAIL %s done_pulse bad=%0d want=0", name, nd); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL %s ready_in_frame bad=%0d want=0", name, busy_bad); end
    @(negedge clk); #1;
    checks++;
    if (tx_ready !== 1'b1 || tx !== 1'b1) begin
      errors++; $display("FAIL %s end_idle ready=%b tx=%b want 1/1", name, tx_ready, tx);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic e1[$];
    div = 16; restart_en = 1'b1;
    model(8'h55, 8, 1'b0, 1'b0, 1'b0);
    e1 = exp_q;
    offer(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b accept1 got=0 want=1"); return; end
    collect(e1.size(), 1'b1, 8'hAA, 1'b0, ok);
    for (int i = 0; i < e1.size(); i++) begin
      checks++;
      if (obs_q[i] !== e1[i]) begin errors++; $display("FAIL b2b f1 bit%0d got=%b want=%b", i, obs_q[i], e1[i]); end
    end
    checks++; if (done_q.size() == 0 || done_q[done_q.size()-1] !== 1'b1) begin errors++; $display("FAIL b2b f1 done got=0 want=1"); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL b2b f1 ready_in_frame bad=%0d want=0", busy_bad); end
    @(negedge clk); #1;
    checks++;
    if (tx_ready !== 1'b1 || baud_restart !== 1'b1 || tx !== 1'b1) begin
      errors++; $display("FAIL b2b gap ready=%b restart=%b tx=%b want 1/1/1", tx_ready, baud_restart, tx);
    end
    model(8'hAA, 8, 1'b0, 1'b0, 1'b0);
    offer(8'hAA, 4'd8, 1'b0, 1'b0, 1'b0, ok);
    collect(exp_q.size(), 1'b0, 8'h00, 1'b0, ok);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b f2 bit%0d got=%b want=%b", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL b2b f2 ready_in_frame bad=%0d want=0", busy_bad); end
    @(negedge clk); #1;
  endtask

  task automatic test_mid_reset();
    bit ok;
    int nt;
    div = 16; restart_en = 1'b1;
    offer(8'hF7, 4'd8, 1'b0, 1'b0, 1'b0, ok);
    nt = 0;
    for (int c = 0; c < 400 && nt < 4; c++) begin
      @(negedge clk); #1;
      tx_valid = 1'b0;
      if (baud_tick) nt++;
    end
    @(negedge clk); #1;
    checks++; if (tx !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL mid_bit3 tx=%b busy=%b want 0/1", tx, tx_busy); end
    n_rst = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx got=%b want=1", tx); end
    checks++; if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_ready ready=%b busy=%b want 1/0", tx_ready, tx_busy); end
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk);
    test_frame("post_reset", 8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      div = $urandom_range(2, 6);
      restart_en = 1'($urandom_range(0, 1));
      test_frame("rand", 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    div = 16; restart_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_frame("8n1_a5", 8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    test_frame("7e1_c1", 8'hC1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    test_frame("5o2_1f", 8'h1F, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    test_back_to_back();
    test_mid_reset();
    test_frame("w0_flip", 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    test_frame("w15_even", 8'h96, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
